tone_sequencer: RTL and testbench

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/nco_pkg.sv | 21 ++
 rtl/tone_sequencer_if.sv | 13 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/tone_sequencer.sv | 108 ++++++++++
 tb/tb_tone_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nco_pkg.sv
// Shared types and default sizing for the tone sequencer and its command FIFO.
package nco_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int FREQ_W_DEF  = 8;
    localparam int DUR_W_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int GAP_CYC_DEF = 2;

    // Pointer width that stays legal for a single-entry FIFO.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Command handshake between a tone producer and the tone sequencer.
interface tone_sequencer_if import nco_pkg::*; #(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int DUR_W  = DUR_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [FREQ_W-1:0] cmd_freq;
    logic [DUR_W-1:0]  cmd_dur;

    modport master (output cmd_valid, output cmd_freq, output cmd_dur, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_freq, input cmd_dur, output cmd_ready);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a flush that empties it in one cycle.
module sync_fifo import nco_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap on plain overflow.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued {freq, dur} tones on an NCO: load, play for dur cycles, then a silent gap.
module tone_sequencer import nco_pkg::*; #(
    parameter int FREQ_W  = FREQ_W_DEF,
    parameter int DUR_W   = DUR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    tone_sequencer_if.slave   cmd,
    input  logic              abort,
    output logic [FREQ_W-1:0] phase_inc,
    output logic              nco_en,
    output logic              phase_clr,
    output logic              tone_done,
    output logic              busy
);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    state_t                    state;
    logic [DUR_W-1:0]          remaining;
    logic [GAP_W-1:0]          gap_cnt;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic [FREQ_W+DUR_W-1:0]   head;
    logic [FREQ_W-1:0]         head_freq;
    logic [DUR_W-1:0]          head_dur;

    // Ready is forced low during reset so nothing is taken while the FIFO is being cleared.
    assign cmd.cmd_ready        = reset_n && !full;
    assign push                 = cmd.cmd_valid && cmd.cmd_ready;
    assign pop                  = (state == LOAD);
    assign {head_freq, head_dur} = head;
    assign busy                 = (state != IDLE) || !empty;

    sync_fifo #(
        .WIDTH (FREQ_W + DUR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (abort),
        .push     (push),
        .pop      (pop),
        .data_in  ({cmd.cmd_freq, cmd.cmd_dur}),
        .data_out (head),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase_inc <= '0;
            nco_en    <= 1'b0;
            phase_clr <= 1'b0;
            tone_done <= 1'b0;
            remaining <= '0;
            gap_cnt   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            nco_en    <= 1'b0;
            phase_clr <= 1'b0;
            tone_done <= 1'b0;
        end else begin
            phase_clr <= 1'b0;
            tone_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) state <= LOAD;
                end
                LOAD: begin
                    // A zero-length tone is consumed silently.
                    if (head_dur == '0) begin
                        state <= IDLE;
                    end else begin
                        phase_inc <= head_freq;
                        remaining <= head_dur;
                        phase_clr <= 1'b1;
                        nco_en    <= 1'b1;
                        state     <= PLAY;
                    end
                end
                PLAY: begin
                    if (remaining == DUR_W'(1)) begin
                        nco_en  <= 1'b0;
                        gap_cnt <= GAP_W'(GAP_CYC);
                        state   <= GAP;
                    end else begin
                        remaining <= remaining - DUR_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        tone_done <= 1'b1;
                        state     <= empty ? IDLE : LOAD;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench: a timeline model predicts acceptance and tone timing; a monitor checks each tone.
module tb_tone_sequencer;

    localparam int FREQ_W  = 8;
    localparam int DUR_W   = 8;
    localparam int DEPTH   = 4;
    localparam int GAP_CYC = 2;

    typedef struct {
        int freq;
        int dur;
        int start;
        int done;
    } tone_t;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              abort   = 1'b0;
    logic [FREQ_W-1:0] phase_inc;
    logic              nco_en;
    logic              phase_clr;
    logic              tone_done;
    logic              busy;

    tone_sequencer_if #(.FREQ_W(FREQ_W), .DUR_W(DUR_W)) cmd_if ();

    tone_sequencer #(
        .FREQ_W  (FREQ_W),
        .DUR_W   (DUR_W),
        .DEPTH   (DEPTH),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd       (cmd_if),
        .abort     (abort),
        .phase_inc (phase_inc),
        .nco_en    (nco_en),
        .phase_clr (phase_clr),
        .tone_done (tone_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int    checks = 0;
    int    fails  = 0;
    tone_t exp_q[$];
    int    occ[$];
    int    t_free = 0;
    bit    cut_at[int];
    bit    mon_on = 1'b0;
    bit    acc;
    int    hs;
    int    last_start;

    bit    in_run = 1'b0;
    int    run_len;
    tone_t cur;
    bit    pend_v = 1'b0;
    int    pend_done;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock cycle of stimulus; the model decides acceptance from FIFO occupancy and
    // schedules each tone on a timeline: load = max(fsm free, accept + 2).
    task automatic step(input bit v, input int f, input int d, input bit ab, input bit rn);
        int  t;
        int  ld;
        bit  rdy;
        bit  bsy;
        t = cyc;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_freq  = FREQ_W'(f);
        cmd_if.cmd_dur   = DUR_W'(d);
        abort            = ab;
        reset_n          = rn;
        while (occ.size() > 0 && occ[0] < t) void'(occ.pop_front());
        rdy = rn && (occ.size() < DEPTH);
        bsy = (occ.size() > 0) || (t < t_free);
        #1;
        check("cmd_ready", int'(cmd_if.cmd_ready), int'(rdy));
        if (mon_on) check("busy", int'(busy), int'(bsy));
        hs  = int'(v && cmd_if.cmd_ready);
        acc = v && rdy && !ab;
        if (acc) begin
            ld = (t_free > t + 2) ? t_free : t + 2;
            occ.push_back(ld);
            if (d != 0) begin
                exp_q.push_back('{f, d, ld + 1, ld + d + GAP_CYC + 1});
                last_start = ld + 1;
                t_free     = ld + d + GAP_CYC + 1;
            end else begin
                t_free = ld + 2;
            end
        end
        if (ab || !rn) begin
            cut_at[t] = 1'b1;
            occ.delete();
            t_free = t + 1;
            while (exp_q.size() > 0 && exp_q[$].start > t) void'(exp_q.pop_back());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    // Monitor: every nco_en run must match the next expected tone, followed by tone_done on time.
    always @(negedge clock) begin
        if (mon_on) begin
            if (cut_at.exists(cyc - 1)) begin
                check("cut_nco_off", int'(nco_en), 0);
                check("cut_no_done", int'(tone_done), 0);
                in_run = 1'b0;
                if (pend_v && pend_done >= cyc) pend_v = 1'b0;
            end else begin
                if (nco_en === 1'b1 && !in_run) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_tone: actual phase_inc %0d, required silence (cycle %0d)",
                                 phase_inc, cyc);
                        cur = '{int'(phase_inc), 0, cyc, -1};
                    end else begin
                        cur = exp_q.pop_front();
                        check("tone_start", cyc, cur.start);
                        check("phase_clr_at_start", int'(phase_clr), 1);
                        check("phase_inc", int'(phase_inc), cur.freq);
                        pend_v    = 1'b1;
                        pend_done = cur.done;
                    end
                    in_run  = 1'b1;
                    run_len = 1;
                end else if (nco_en === 1'b1) begin
                    run_len++;
                    check("phase_inc_hold", int'(phase_inc), cur.freq);
                    check("phase_clr_single", int'(phase_clr), 0);
                end else begin
                    if (in_run) begin
                        in_run = 1'b0;
                        check("tone_len", run_len, cur.dur);
                    end
                    check("phase_clr_idle", int'(phase_clr), 0);
                end
                if (tone_done === 1'b1) begin
                    check("tone_done_cycle", cyc, pend_v ? pend_done : -1);
                    pend_v = 1'b0;
                end else if (pend_v && cyc >= pend_done) begin
                    checks++;
                    fails++;
                    $display("FAIL tone_done_missing: actual none, required cycle %0d", pend_done);
                    pend_v = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        int n;
        int k2;
        int s;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_freq  = '0;
        cmd_if.cmd_dur   = '0;
        @(posedge clock);
        #1;
        repeat (3) step(1'b0, 0, 0, 1'b0, 1'b0);
        mon_on = 1'b1;
        check("rst_nco_en", int'(nco_en), 0);
        check("rst_phase_clr", int'(phase_clr), 0);
        check("rst_tone_done", int'(tone_done), 0);
        check("rst_phase_inc", int'(phase_inc), 0);
        check("rst_busy", int'(busy), 0);

        // Single tone, then a back-to-back pair, then a skipped zero-length tone.
        step(1'b1, 5, 3, 1'b0, 1'b1);
        idle(12);
        step(1'b1, 7, 2, 1'b0, 1'b1);
        step(1'b1, 9, 1, 1'b0, 1'b1);
        idle(12);
        check("busy_after_pair", int'(busy), 0);
        step(1'b1, 3, 0, 1'b0, 1'b1);
        step(1'b1, 4, 1, 1'b0, 1'b1);
        idle(10);

        // Long tone stalls the FSM so the FIFO fills.
        step(1'b1, 1, 200, 1'b0, 1'b1);
        idle(4);
        i = 0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 20 + i, 1 + (i % 3), 1'b0, 1'b1);
            n += hs;
            if (acc) i++;
        end
        check("stall_accepted", n, 4);
        check("stall_ready", int'(cmd_if.cmd_ready), 0);
        k2 = 0;
        while (i < 5 && k2 < 400) begin
            step(1'b1, 20 + i, 1 + (i % 3), 1'b0, 1'b1);
            if (acc) i++;
            k2++;
        end
        check("fifth_accepted", i, 5);
        idle(40);

        // Abort in the second PLAY cycle with two tones queued.
        step(1'b1, 6, 10, 1'b0, 1'b1);
        s = last_start;
        step(1'b1, 11, 2, 1'b0, 1'b1);
        step(1'b1, 12, 2, 1'b0, 1'b1);
        k2 = 0;
        while (cyc < s + 1 && k2 < 20) begin
            idle(1);
            k2++;
        end
        step(1'b0, 0, 0, 1'b1, 1'b1);
        check("abort_nco_en", int'(nco_en), 0);
        check("abort_tone_done", int'(tone_done), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(cmd_if.cmd_ready), 1);
        idle(20);

        // One-cycle reset in the middle of a tone with commands queued.
        step(1'b1, 2, 20, 1'b0, 1'b1);
        s = last_start;
        step(1'b1, 13, 1, 1'b0, 1'b1);
        step(1'b1, 14, 1, 1'b0, 1'b1);
        k2 = 0;
        while (cyc < s + 3 && k2 < 20) begin
            idle(1);
            k2++;
        end
        step(1'b0, 0, 0, 1'b0, 1'b0);
        check("reset_nco_en", int'(nco_en), 0);
        check("reset_phase_clr", int'(phase_clr), 0);
        check("reset_tone_done", int'(tone_done), 0);
        check("reset_phase_inc", int'(phase_inc), 0);
        check("reset_busy", int'(busy), 0);
        idle(20);

        // Random traffic with occasional aborts.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 2) != 0), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 6)), ($urandom_range(0, 79) == 0), 1'b1);
        end
        idle(60);
        check("scoreboard_drained", exp_q.size(), 0);
        check("no_open_tone", int'(in_run), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
